// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaled period counter, per-channel
// double-buffered duty, output/PWM enables and polarity, registered outputs.
module pwm_multi_channel #(
  parameter int unsigned NUM_CH  = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [NUM_CH-1:0]  en_out,
  input  logic [NUM_CH-1:0]  en_pwm,
  input  logic [NUM_CH-1:0]  polarity,
  input  logic               wr_en,
  input  logic [7:0]         wr_addr,
  input  logic [CNT_W-1:0]   wr_data,
  output logic [NUM_CH-1:0]  out,
  output logic               period_done
);

  localparam int unsigned AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_act_q, per_act_d;
  logic [PRESC_W-1:0] presc_act_q, presc_act_d;
  logic [CNT_W-1:0]   duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0]   duty_sh_d  [NUM_CH];
  logic [CNT_W-1:0]   duty_act_q [NUM_CH];
  logic [CNT_W-1:0]   duty_act_d [NUM_CH];
  logic [NUM_CH-1:0]  out_q, out_d;
  logic               wrap_q, wrap_d;
  logic               period_done_q, period_done_d;
  logic               tick;
  logic               wrap;
  logic [NUM_CH-1:0]  lvl;

  assign tick = (pre_cnt_q == presc_act_q);
  assign wrap = run && tick && (cnt_q == per_act_q);

  // Counters and active period/prescale; while stopped, settings track the inputs
  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    cnt_d       = cnt_q;
    per_act_d   = per_act_q;
    presc_act_d = presc_act_q;
    if (!run) begin
      pre_cnt_d   = '0;
      cnt_d       = '0;
      per_act_d   = period;
      presc_act_d = prescale;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESC_W'(1);
      if (tick) begin
        cnt_d = (cnt_q == per_act_q) ? '0 : cnt_q + CNT_W'(1);
      end
      if (wrap) begin
        per_act_d   = period;
        presc_act_d = prescale;
      end
    end
  end

  // Wrap flag is delayed one cycle so period_done lines up with the first new output
  always_comb begin
    wrap_d        = wrap;
    period_done_d = wrap_q && run;
  end

  // Shadow writes and shadow-to-active transfer (transfer sees pre-write contents)
  always_comb begin
    duty_sh_d  = duty_sh_q;
    duty_act_d = duty_act_q;
    if (!run || wrap) begin
      duty_act_d = duty_sh_q;
    end
    if (wr_en && (32'(wr_addr) < NUM_CH)) begin
      duty_sh_d[wr_addr[AW-1:0]] = wr_data;
    end
  end

  always_comb begin
    lvl = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (duty_act_q[i] == '0) begin
        lvl[i] = 1'b0;
      end else if (duty_act_q[i] > per_act_q) begin
        lvl[i] = 1'b1;
      end else begin
        lvl[i] = (cnt_q < duty_act_q[i]);
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (en_out[i]) begin
        out_d[i] = en_pwm[i] ? (lvl[i] ^ polarity[i]) : ~polarity[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      per_act_q     <= '1;
      presc_act_q   <= '0;
      duty_sh_q     <= '{default: '0};
      duty_act_q    <= '{default: '0};
      out_q         <= '0;
      wrap_q        <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      per_act_q     <= per_act_d;
      presc_act_q   <= presc_act_d;
      duty_sh_q     <= duty_sh_d;
      duty_act_q    <= duty_act_d;
      out_q         <= out_d;
      wrap_q        <= wrap_d;
      period_done_q <= period_done_d;
    end
  end

  assign out         = out_q;
  assign period_done = period_done_q;

endmodule
